// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson phase scheduler: FSM states and
// the Johnson step function used by the counter core.
package johnson_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sched_state_t;

  localparam int JOHNSON_MAX_W = 32;
  localparam logic [JOHNSON_MAX_W-1:0] JOHNSON_ZERO = '0;

  // Shift left, feeding back the inverted top stage of a width-bit counter.
  function automatic logic [JOHNSON_MAX_W-1:0] johnson_next(
    input logic [JOHNSON_MAX_W-1:0] cnt,
    input int unsigned              width
  );
    logic [JOHNSON_MAX_W-1:0] mask;
    logic                     tap;
    mask = (JOHNSON_MAX_W'(1) << width) - JOHNSON_MAX_W'(1);
    tap  = |(cnt & (JOHNSON_MAX_W'(1) << (width - 1)));
    return {cnt[JOHNSON_MAX_W-2:0], ~tap} & mask;
  endfunction

endpackage

// File: rtl/johnson_core.sv
// WIDTH-stage Johnson counter; steps once per cycle while adv is high.
module johnson_core
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             adv,
  output logic [WIDTH-1:0] cnt
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk) begin
    if (Reset) begin
      cnt <= '0;
    end else if (adv) begin
      cnt <= WIDTH'(johnson_next(JOHNSON_MAX_W'(cnt), WIDTH));
    end
  end

endmodule

// File: rtl/johnson_phase_sched.sv
// Round-robin scheduler that lends one Johnson phase generator to N_REQ
// requesters, one burst at a time, draining the counter to zero between bursts.
module johnson_phase_sched
  import johnson_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
) (
  input  logic                   clk,
  input  logic                   Reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LEN_W-1:0] req_len,
  input  logic                   abort,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic [WIDTH-1:0]       phase_out,
  output logic                   phase_valid,
  output logic [N_REQ-1:0]       done,
  output logic                   aborted
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  sched_state_t     state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] win_q;
  logic [LEN_W-1:0] rem;
  logic             aborted_r;
  logic [WIDTH-1:0] cnt;
  logic             adv;
  logic             any_req;
  logic [PTR_W-1:0] win_idx;
  logic [LEN_W-1:0] len_sel;

  johnson_core #(.WIDTH(WIDTH)) u_core (
    .clk  (clk),
    .Reset(Reset),
    .adv  (adv),
    .cnt  (cnt)
  );

  assign phase_out = cnt;
  assign adv       = (state == RUN) || ((state == DRAIN) && (cnt != WIDTH'(JOHNSON_ZERO)));
  assign len_sel   = req_len[win_idx*LEN_W +: LEN_W];

  // Round-robin pick: scan requests starting at rr_ptr and wrapping, so the
  // lowest rotated index wins and is mapped back to an absolute requester.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value held and infer a latch.
  always_comb begin
    int j;
    any_req = 1'b0;
    win_idx = '0;
    j       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!any_req && req[PTR_W'(j)]) begin
        any_req = 1'b1;
        win_idx = PTR_W'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      win_q       <= '0;
      rem         <= '0;
      aborted_r   <= 1'b0;
      gnt         <= '0;
      busy        <= 1'b0;
      phase_valid <= 1'b0;
      done        <= '0;
      aborted     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt       <= N_REQ'(1) << win_idx;
            win_q     <= win_idx;
            rem       <= len_sel;
            aborted_r <= 1'b0;
            busy      <= 1'b1;
            if (len_sel != '0) begin
              state       <= RUN;
              phase_valid <= 1'b1;
            end else begin
              state   <= DONE;
              done    <= N_REQ'(1) << win_idx;
              aborted <= 1'b0;
            end
          end
        end
        RUN: begin
          rem <= rem - LEN_W'(1);
          // The current cycle is still a valid step even when it is the last.
          if (rem == LEN_W'(1) || abort) begin
            state       <= DRAIN;
            phase_valid <= 1'b0;
            aborted_r   <= abort;
          end
        end
        DRAIN: begin
          if (cnt == WIDTH'(JOHNSON_ZERO)) begin
            state   <= DONE;
            done    <= gnt;
            aborted <= aborted_r;
          end
        end
        DONE: begin
          state   <= IDLE;
          gnt     <= '0;
          busy    <= 1'b0;
          done    <= '0;
          aborted <= 1'b0;
          rr_ptr  <= (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + PTR_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_johnson_phase_sched.sv
// Bench for johnson_phase_sched: table of bursts plus hand-written reset
// sequences; a negedge monitor compares phases and done events from queues.
module tb_johnson_phase_sched;

  localparam int N_REQ = 4;
  localparam int WIDTH = 4;
  localparam int LEN_W = 8;

  logic                   clk = 1'b0;
  logic                   Reset;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*LEN_W-1:0] req_len;
  logic                   abort;
  logic [N_REQ-1:0]       gnt;
  logic                   busy;
  logic [WIDTH-1:0]       phase_out;
  logic                   phase_valid;
  logic [N_REQ-1:0]       done;
  logic                   aborted;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] lens;
    int          abort_at;
    bit          abort_drain;
    bit          drop_req;
    logic [3:0]  exp_gnt;
  } vec_t;

  typedef struct {
    logic [3:0] phase;
    logic [3:0] gnt;
  } ph_t;

  typedef struct {
    logic [3:0] gnt;
    logic       ab;
  } ev_t;

  ph_t  ph_q[$];
  ev_t  ev_q[$];
  vec_t vecs[12];

  logic [3:0] jseq[8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                          4'b1111, 4'b1110, 4'b1100, 4'b1000};

  always #5 clk = ~clk;

  johnson_phase_sched #(.N_REQ(N_REQ), .WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .req        (req),
    .req_len    (req_len),
    .abort      (abort),
    .gnt        (gnt),
    .busy       (busy),
    .phase_out  (phase_out),
    .phase_valid(phase_valid),
    .done       (done),
    .aborted    (aborted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int eff_steps(input int len, input int abort_at);
    if (abort_at != 0 && abort_at < len) return abort_at;
    return len;
  endfunction

  // Cycles from first grant to done: steps, then drain back to 0000 inclusive.
  function automatic int exp_latency(input int len, input int abort_at);
    int s;
    int p;
    s = eff_steps(len, abort_at);
    if (s == 0) return 0;
    p = s % 8;
    return s + ((p == 0) ? 1 : 9 - p);
  endfunction

  task automatic push_burst(input logic [3:0] g, input int len, input int abort_at);
    int s;
    s = eff_steps(len, abort_at);
    for (int k = 0; k < s; k++) ph_q.push_back('{jseq[k % 8], g});
    ev_q.push_back('{g, (abort_at != 0 && abort_at <= len)});
  endtask

  task automatic wait_done(input int abort_at, input bit abort_drain, input bit drop_req,
                           input int exp_lat, output int gcyc);
    int cyc;
    int nvalid;
    bit seen;
    cyc    = 0;
    nvalid = 0;
    seen   = 1'b0;
    gcyc   = -1;
    while (!seen && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (gcyc < 0 && gnt != '0) gcyc = cyc;
      if (phase_valid) begin
        nvalid++;
        if (drop_req) req = '0;
        abort = (abort_at != 0 && nvalid == abort_at);
      end else begin
        abort = abort_drain && (nvalid > 0);
      end
      if (done != '0) begin
        seen = 1'b1;
        check("latency", cyc - gcyc, exp_lat);
      end
    end
    abort = 1'b0;
    req   = '0;
    if (!seen) check("done_timeout", 0, 1);
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    ph_t pe;
    ev_t ee;
    if (phase_valid) begin
      if (ph_q.size() == 0) begin
        check("unexpected_valid", phase_valid, 0);
      end else begin
        pe = ph_q.pop_front();
        check("phase", phase_out, pe.phase);
        check("gnt_run", gnt, pe.gnt);
      end
    end
    if (done != '0) begin
      if (ev_q.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        ee = ev_q.pop_front();
        check("done", done, ee.gnt);
        check("aborted", aborted, ee.ab);
        check("gnt_at_done", gnt, ee.gnt);
        check("cnt_at_done", phase_out, 0);
      end
    end else if (aborted) begin
      check("aborted_alone", aborted, 0);
    end
    if (!Reset) check("busy_vs_gnt", busy, gnt != '0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int widx;
    int len;
    int n;

    vecs[0]  = '{4'b1111, 32'h01010101, 0, 1'b0, 1'b0, 4'b0001};
    vecs[1]  = '{4'b1111, 32'h01010101, 0, 1'b0, 1'b0, 4'b0010};
    vecs[2]  = '{4'b1111, 32'h01010101, 0, 1'b0, 1'b0, 4'b0100};
    vecs[3]  = '{4'b1111, 32'h01010101, 0, 1'b0, 1'b0, 4'b1000};
    vecs[4]  = '{4'b1111, 32'h01010101, 0, 1'b0, 1'b0, 4'b0001};
    vecs[5]  = '{4'b0001, 32'h00000003, 0, 1'b0, 1'b0, 4'b0001};
    vecs[6]  = '{4'b0100, 32'h05000509, 0, 1'b0, 1'b0, 4'b0100};
    vecs[7]  = '{4'b0010, 32'h00001400, 4, 1'b0, 1'b0, 4'b0010};
    vecs[8]  = '{4'b1000, 32'h02000000, 0, 1'b1, 1'b0, 4'b1000};
    vecs[9]  = '{4'b0110, 32'h00090500, 0, 1'b0, 1'b0, 4'b0010};
    vecs[10] = '{4'b0011, 32'h00000F0A, 0, 1'b0, 1'b1, 4'b0001};
    vecs[11] = '{4'b0001, 32'h00000008, 0, 1'b0, 1'b0, 4'b0001};

    // Reset held with a pending request: everything stays quiet.
    Reset   = 1'b1;
    req     = 4'b0001;
    req_len = 32'h00000005;
    abort   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", phase_valid, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_phase", phase_out, 0);
    push_burst(4'b0001, 5, 0);
    Reset = 1'b0;
    wait_done(0, 1'b0, 1'b0, exp_latency(5, 0), g);
    check("gnt_latency", g, 1);

    // Reset again so the round-robin pointer restarts at requester 0.
    Reset = 1'b1;
    repeat (2) @(negedge clk);
    Reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      widx = 0;
      for (int b = 0; b < 4; b++) if (vecs[i].exp_gnt[b]) widx = b;
      len     = int'(vecs[i].lens[widx*8 +: 8]);
      req     = vecs[i].req;
      req_len = vecs[i].lens;
      push_burst(vecs[i].exp_gnt, len, vecs[i].abort_at);
      wait_done(vecs[i].abort_at, vecs[i].abort_drain, vecs[i].drop_req,
                exp_latency(len, vecs[i].abort_at), g);
    end
    @(negedge clk);
    check("sb_empty", ph_q.size() + ev_q.size(), 0);

    // Reset in the middle of a burst: no done pulse, straight back to idle.
    req     = 4'b0001;
    req_len = 32'h00000008;
    push_burst(4'b0001, 8, 0);
    n = 0;
    for (int c = 0; c < 50 && n < 3; c++) begin
      @(negedge clk);
      if (phase_valid) n++;
    end
    check("mid_run_reached", n, 3);
    Reset = 1'b1;
    req   = '0;
    @(negedge clk);
    Reset = 1'b0;
    ph_q.delete();
    ev_q.delete();
    check("midrst_gnt", gnt, 0);
    check("midrst_busy", busy, 0);
    check("midrst_valid", phase_valid, 0);
    check("midrst_phase", phase_out, 0);
    check("midrst_done", done, 0);
    repeat (20) @(negedge clk);
    check("idle_after_reset", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
